cdc_fifo_read_arbiter: RTL and testbench
========================================

# cdc_fifo_read_arbiter

Read-side scheduler that shares one downstream consumer among CHANNELS asynchronous FIFOs, all read in the consumer's clock domain. Each cycle it picks one non-empty FIFO, pulses that FIFO's read-state `increment`, captures the word at its read address into a one-entry output register, and presents it as a valid/ready stream tagged with the source channel. Arbitration is round-robin with a per-grant burst limit, so one busy channel cannot starve the others.

## Interface
- `CHANNELS`, 4: number of FIFOs arbitrated; ≥2.
- `DATA_WIDTH`, 8: FIFO word width.
- `BURST_MAX`, 4: maximum consecutive pops from one channel before it must yield; ≥1.
- `clock` input 1: consumer-domain clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high.
- `empty` input CHANNELS: per-channel empty flag from each FIFO's read state; bit i = channel i.
- `read_data` input CHANNELS×DATA_WIDTH: word at each FIFO's current read address; combinational array read, valid whenever `empty[i]`=0.
- `increment` output CHANNELS: per-channel pop strobe to the FIFO read state; one-hot or zero.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: consumer accepts the word this cycle.
- `out_data` output DATA_WIDTH: popped word.
- `out_channel` output CH_W: source channel of `out_data`; CH_W = max(1, $clog2(CHANNELS)).

## Operation
- `load` = !out_valid | out_ready. A pop occurs only when `load`=1 and a candidate exists. With `load`=0, all state holds and `increment`=0.
- State: IDLE (no owner) or LOCKED (owner channel, burst count 1..BURST_MAX-1). Also kept: `last`, the most recently granted channel.
- Candidate selection:
  - If LOCKED and `empty[owner]`=0, candidate = owner.
  - Otherwise, candidate = first non-empty channel scanning `base+1, base+2, …` modulo CHANNELS, where `base` = owner if LOCKED, else `last`. No candidate if all channels are empty.
- On pop of channel c:
  - `increment[c]`=1 in the same cycle (combinational).
  - Register updates: `out_data`←`read_data[c]`, `out_channel`←c, `out_valid`←1, `last`←c.
  - If c continues the current lock, count increments. If count reaches BURST_MAX → IDLE.
  - Otherwise: if BURST_MAX=1 → IDLE; else LOCKED with owner=c, count=1.
- No pop but `out_ready`=1: `out_valid`←0.
- If the owner goes empty mid-burst, the lock is released and the next non-empty channel after the owner is popped in the same cycle, with no bubble. If no other channel is non-empty → IDLE.
- BURST_MAX=1 degenerates to pure round-robin, one word per grant.
- Never pops an empty channel. `increment` is suppressed while `reset` is asserted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_channel`=0, state IDLE, count 0, `last`=CHANNELS-1 (channel 0 has first priority after reset).
- Latency: word visible on `out_data` one cycle after its `increment` pulse.
- Throughput: one word per cycle while `out_ready`=1 and any channel is non-empty.
- Stream rule: once `out_valid`=1, `out_data` and `out_channel` are held stable until accepted.
- Reset mid-burst: all state clears asynchronously. The register contents are dropped, and the FIFO entry already popped is lost. This is accepted.

## Structure
- Package `cdc_fifo_pkg`: `CH_W` function, `arb_state_e` enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module `round_robin_picker` (combinational): inputs `request[CHANNELS]` and `base`; outputs `found` and `index`, the first set bit after `base` with wrap-around. Instantiated once.
- Burst counter width: $clog2(BURST_MAX+1).

## Test plan
- Reset, all channels empty, `out_ready`=1 → `out_valid`=0, `increment`=0, `out_channel`=0 for 10 cycles.
- Channel 2 only, 3 words 0xA1/0xA2/0xA3, `out_ready`=1 → `increment[2]` pulses three consecutive cycles; outputs 0xA1, 0xA2, 0xA3 with `out_channel`=2; `out_valid` low afterwards.
- Channels 0 and 1 each hold 6 words, BURST_MAX=4 → output channel order 0,0,0,0,1,1,1,1,0,0,1,1.
- `out_ready` held low for 5 cycles with `out_valid`=1 → `out_data` stable, no `increment`; on release, pops resume next cycle at 1/cycle.
- Channel 1 locked with count 2 and goes empty; channel 3 non-empty → next cycle pops channel 3 with no bubble, state LOCKED owner=3, count 1.
- Assert `reset` mid-burst → `out_valid`=0 immediately; after release, channel 0 wins when all channels are non-empty.

Source files
------------

// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared types and sizing helpers for the FIFO read-side arbiter
package cdc_fifo_pkg;
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
   function automatic int CH_W(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/round_robin_picker.sv
// round_robin_picker: first set request bit after base, wrapping around
module round_robin_picker import cdc_fifo_pkg::*; #(
   parameter int CHANNELS = 4
) (
   input  logic [CHANNELS-1:0]        request,
   input  logic [CH_W(CHANNELS)-1:0]  base,
   output logic                       found,
   output logic [CH_W(CHANNELS)-1:0]  index
);
   localparam int CW = CH_W(CHANNELS);
   logic [CW-1:0] w_idx;
   // scan farthest-first so the nearest hit after base overwrites the rest
   always_comb begin
      found = 1'b0;
      index = '0;
      w_idx = '0;
      for (int k = CHANNELS; k >= 1; k--) begin
         w_idx = CW'((int'(base) + k) % CHANNELS);
         if (request[w_idx]) begin
            found = 1'b1;
            index = w_idx;
         end
      end
   end
endmodule

// File: rtl/cdc_fifo_read_arbiter.sv
// cdc_fifo_read_arbiter: round-robin, burst-limited pop scheduler over several FIFOs into one stream
module cdc_fifo_read_arbiter import cdc_fifo_pkg::*; #(
   parameter int CHANNELS   = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            empty,
   input  logic [CHANNELS*DATA_WIDTH-1:0] read_data,
   output logic [CHANNELS-1:0]            increment,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [CH_W(CHANNELS)-1:0]      out_channel
);
   localparam int CW = CH_W(CHANNELS);
   localparam int BW = $clog2(BURST_MAX + 1);
   arb_state_e            r_state;
   logic [CW-1:0]         r_owner;
   logic [CW-1:0]         r_last;
   logic [BW-1:0]         r_count;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CW-1:0]         r_channel;
   logic                  w_load;
   logic                  w_hold_owner;
   logic                  w_found;
   logic                  w_pop;
   logic                  w_burst_done;
   logic [CW-1:0]         w_base;
   logic [CW-1:0]         w_pick;
   logic [CW-1:0]         w_cand;
   logic [BW-1:0]         w_next_count;
   assign w_load       = !r_valid || out_ready;
   assign w_hold_owner = (r_state == ARB_LOCKED) && !empty[r_owner];
   assign w_base       = (r_state == ARB_LOCKED) ? r_owner : r_last;
   round_robin_picker #(.CHANNELS(CHANNELS)) u_picker (
      .request(~empty),
      .base   (w_base),
      .found  (w_found),
      .index  (w_pick)
   );
   assign w_cand       = w_hold_owner ? r_owner : w_pick;
   assign w_pop        = w_load && (w_hold_owner || w_found) && !reset;
   assign increment    = w_pop ? (CHANNELS'(1) << w_cand) : '0;
   assign w_next_count = r_count + BW'(1);
   assign w_burst_done = w_next_count == BW'(BURST_MAX);
   assign out_valid    = r_valid;
   assign out_data     = r_data;
   assign out_channel  = r_channel;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ARB_IDLE;
         r_owner   <= '0;
         r_last    <= CW'(CHANNELS - 1);
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_channel <= '0;
      end else if (w_pop) begin
         r_valid   <= 1'b1;
         r_data    <= read_data[w_cand*DATA_WIDTH +: DATA_WIDTH];
         r_channel <= w_cand;
         r_last    <= w_cand;
         if (w_hold_owner) begin
            r_count <= w_burst_done ? '0 : w_next_count;
            r_state <= w_burst_done ? ARB_IDLE : ARB_LOCKED;
         end else begin
            r_owner <= w_cand;
            r_count <= (BURST_MAX == 1) ? '0 : BW'(1);
            r_state <= (BURST_MAX == 1) ? ARB_IDLE : ARB_LOCKED;
         end
      end else if (w_load) begin
         // loading with nothing to pop: every channel is empty, so drop any lock
         r_valid <= 1'b0;
         r_state <= ARB_IDLE;
         r_count <= '0;
      end
   end
endmodule

// File: tb/tb_cdc_fifo_read_arbiter.sv
// tb_cdc_fifo_read_arbiter: directed tables, corner sequences and random traffic against a queue-based model
module tb_cdc_fifo_read_arbiter;
   localparam int CH = 4;
   localparam int DW = 8;
   localparam int BM = 4;
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] empty;
   logic [CH*DW-1:0] read_data;
   logic [CH-1:0] increment;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    out_channel;
   always #5 clock = ~clock;
   cdc_fifo_read_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
      .clock(clock), .reset(reset), .empty(empty), .read_data(read_data),
      .increment(increment), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_channel(out_channel)
   );
   logic [DW-1:0] q [CH][$];
   int checks = 0;
   int failures = 0;
   bit m_valid;
   logic [DW-1:0] m_data;
   int m_ch, m_owner, m_count, m_last;
   bit m_locked;
   int last_pick;
   logic [CH-1:0] last_inc;
   typedef struct {
      bit            ready;
      bit            exp_valid;
      int            exp_ch;
      logic [DW-1:0] exp_data;
   } vec_t;
   vec_t tbl[13];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic drive_fifo();
      for (int i = 0; i < CH; i++) begin
         empty[i] = q[i].size() == 0;
         read_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : '0;
      end
   endtask
   task automatic clear_q();
      for (int i = 0; i < CH; i++) q[i].delete();
   endtask
   task automatic model_reset();
      m_valid = 0; m_data = '0; m_ch = 0; m_locked = 0;
      m_owner = 0; m_count = 0; m_last = CH - 1;
   endtask
   function automatic int model_pick();
      int base;
      if (reset || (m_valid && !out_ready)) return -1;
      if (m_locked && q[m_owner].size() != 0) return m_owner;
      base = m_locked ? m_owner : m_last;
      for (int k = 1; k <= CH; k++)
         if (q[(base + k) % CH].size() != 0) return (base + k) % CH;
      return -1;
   endfunction
   task automatic model_commit(input int c);
      if (c >= 0) begin
         m_data = q[c].pop_front();
         m_ch = c; m_valid = 1; m_last = c;
         if (m_locked && c == m_owner) begin
            m_count++;
            if (m_count == BM) begin m_locked = 0; m_count = 0; end
         end else if (BM == 1) begin
            m_locked = 0; m_count = 0;
         end else begin
            m_locked = 1; m_owner = c; m_count = 1;
         end
      end else if (!m_valid || out_ready) begin
         m_valid = 0; m_locked = 0; m_count = 0;
      end
   endtask
   task automatic step(input bit rdy);
      out_ready = rdy;
      drive_fifo();
      #1;
      last_pick = model_pick();
      last_inc = increment;
      check("increment", increment, (last_pick >= 0) ? (32'd1 << last_pick) : 32'd0);
      @(posedge clock);
      #1;
      model_commit(last_pick);
      drive_fifo();
      @(negedge clock);
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("out_data", out_data, m_data);
         check("out_channel", out_channel, m_ch);
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_inc", increment, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask
   initial begin
      int ord[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
      int n[2] = '{0, 0};
      out_ready = 1'b1;
      clear_q();
      drive_fifo();
      model_reset();
      @(negedge clock);
      check("rst_data", out_data, 0);
      check("rst_chan", out_channel, 0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("idle_valid", out_valid, 0);
         check("idle_inc", last_inc, 0);
         check("idle_chan", out_channel, 0);
      end
      // single channel, three words
      push_words(2, 8'hA1, 3);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("ch2_inc", last_inc, 4'b0100);
         check("ch2_data", out_data, 8'hA1 + i);
         check("ch2_chan", out_channel, 2);
      end
      step(1);
      check("ch2_drained", out_valid, 0);
      // two busy channels, burst limit visible in the channel order
      do_reset();
      clear_q();
      push_words(0, 8'h10, 6);
      push_words(1, 8'h20, 6);
      for (int i = 0; i < 12; i++) begin
         tbl[i] = '{ready: 1'b1, exp_valid: 1'b1, exp_ch: ord[i],
                    exp_data: 8'((ord[i] + 1) * 16 + n[ord[i]])};
         n[ord[i]]++;
      end
      tbl[12] = '{ready: 1'b1, exp_valid: 1'b0, exp_ch: 0, exp_data: 8'h00};
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].ready);
         check("tbl_valid", out_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid) begin
            check("tbl_chan", out_channel, tbl[i].exp_ch);
            check("tbl_data", out_data, tbl[i].exp_data);
         end
      end
      // backpressure holds the word and stops pops
      do_reset();
      clear_q();
      push_words(0, 8'h30, 8);
      step(1);
      for (int i = 0; i < 5; i++) begin
         step(0);
         check("bp_inc", last_inc, 0);
         check("bp_data", out_data, 8'h30);
         check("bp_valid", out_valid, 1);
      end
      for (int i = 1; i <= 3; i++) begin
         step(1);
         check("bp_resume_inc", last_inc, 4'b0001);
         check("bp_resume_data", out_data, 8'h30 + i);
      end
      // owner empties mid-burst: hand over without a bubble
      do_reset();
      clear_q();
      push_words(1, 8'h41, 2);
      push_words(3, 8'h61, 2);
      step(1);
      step(1);
      check("handover_pre_chan", out_channel, 1);
      step(1);
      check("handover_inc", last_inc, 4'b1000);
      check("handover_data", out_data, 8'h61);
      check("handover_state", dut.r_state, 1);
      check("handover_owner", dut.r_owner, 3);
      check("handover_count", dut.r_count, 1);
      // reset in the middle of a burst
      clear_q();
      for (int c = 0; c < CH; c++) push_words(c, 8'(8'h70 + 16 * c), 4);
      do_reset();
      step(1);
      step(1);
      do_reset();
      step(1);
      check("post_rst_inc", last_inc, 4'b0001);
      // random traffic against the model
      do_reset();
      clear_q();
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 2) != 0) begin
            int c = $urandom_range(0, CH - 1);
            if (q[c].size() < 8) q[c].push_back(8'($urandom));
         end
         step($urandom_range(0, 3) != 0);
      end
      for (int t = 0; t < 40; t++) step(1);
      check("rand_drained", out_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   task automatic push_words(input int c, input logic [DW-1:0] first, input int cnt);
      for (int i = 0; i < cnt; i++) q[c].push_back(first + DW'(i));
   endtask
endmodule
